// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle radix-2 shift-add sequencer for mul/mulh/mulhu with pipeline stall
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, acc_fin;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic               neg, low, is_mul, is_mulh, accept, last;
  // decode, next state, handshake outputs and the per-iteration adder
  always_comb begin
    is_mul    = aluop == 4'b0101 || aluop == 4'b0110 || aluop == 4'b0111;
    is_mulh   = aluop == 4'b0110;
    accept    = state == IDLE && start && is_mul;
    last      = cnt == CW'(WIDTH - 1);
    a_mag     = a[WIDTH-1] ? ~a + 1'b1 : a;
    b_mag     = b[WIDTH-1] ? ~b + 1'b1 : b;
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
    acc_fin   = neg ? ~acc + 1'b1 : acc;
    state_nxt = state == IDLE ? (accept ? RUN : IDLE) :
                state == RUN  ? (last ? SIGN : RUN) :
                state == SIGN ? DONE : IDLE;
    busy      = state != IDLE;
    stall     = accept || state == RUN || state == SIGN;
    done      = state == DONE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // operand latch, shift-add iterations, sign fix-up and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      low    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand  <= is_mulh ? a_mag : a;
          mplier <= is_mulh ? b_mag : b;
          neg    <= is_mulh && (a[WIDTH-1] ^ b[WIDTH-1]);
          low    <= aluop == 4'b0101;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        SIGN: begin
          acc    <= acc_fin;
          result <= low ? acc_fin[WIDTH-1:0] : acc_fin[2*WIDTH-1:WIDTH];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed checks of latency, stall/busy/done handshake and products
module tb_mul_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0]  aluop = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, stall, done;
  logic [31:0] result;
  int n_checks = 0, n_fail = 0, cyc = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // issue one op; lat = cycle of done relative to accept, bad = handshake violations
  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat, output int bad, output int dcyc);
    bad = 0; lat = -1; r = '0; dcyc = -1;
    @(posedge clk); #1;
    start = 1'b1; aluop = op; a = x; b = y;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k; r = result; dcyc = cyc;
        if (stall !== 1'b0 || busy !== 1'b1) bad++;
        break;
      end
      if (stall !== 1'b1 || busy !== (k > 0)) bad++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
    n_checks++; if (stall !== 1'b0) begin $display("FAIL reset_stall got %b want 0", stall); n_fail++; end
    n_checks++; if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); n_fail++; end
    n_checks++; if (result !== 32'h0) begin $display("FAIL reset_result got %h want 0", result); n_fail++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_mul_basic;
    logic [31:0] r; int lat, bad, dc;
    do_op(4'b0101, 32'd7, 32'd6, r, lat, bad, dc);
    n_checks++; if (r !== 32'h2A) begin $display("FAIL mul7x6 got %h want 0000002a", r); n_fail++; end
    n_checks++; if (lat !== 34) begin $display("FAIL mul7x6_latency got %0d want 34", lat); n_fail++; end
    n_checks++; if (bad !== 0) begin $display("FAIL mul7x6_stall_busy got %0d bad cycles want 0", bad); n_fail++; end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin $display("FAIL done_pulse_width got %b want 0", done); n_fail++; end
    n_checks++; if (result !== 32'h2A) begin $display("FAIL result_hold got %h want 0000002a", result); n_fail++; end
    n_checks++; if (busy !== 1'b0) begin $display("FAIL idle_busy got %b want 0", busy); n_fail++; end
  endtask

  task automatic test_mulhu;
    logic [31:0] r; int lat, bad, dc;
    do_op(4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bad, dc);
    n_checks++; if (r !== 32'hFFFFFFFE) begin $display("FAIL mulhu_ff got %h want fffffffe", r); n_fail++; end
    do_op(4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bad, dc);
    n_checks++; if (r !== 32'h00000001) begin $display("FAIL mul_ff got %h want 00000001", r); n_fail++; end
  endtask

  task automatic test_mulh;
    logic [31:0] xs [4] = '{32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};
    logic [31:0] ys [4] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    logic [31:0] ex [4] = '{32'h40000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] r; int lat, bad, dc;
    for (int i = 0; i < 4; i++) begin
      do_op(4'b0110, xs[i], ys[i], r, lat, bad, dc);
      n_checks++;
      if (r !== ex[i]) begin
        $display("FAIL mulh_%0d %h*%h got %h want %h", i, xs[i], ys[i], r, ex[i]); n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; int lat, bad, dc;
    @(posedge clk); #1;
    start = 1'b1; aluop = 4'b0101; a = 32'd3; b = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 10) rst_n = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin $display("FAIL midrst_busy got %b want 0", busy); n_fail++; end
    n_checks++; if (stall !== 1'b0) begin $display("FAIL midrst_stall got %b want 0", stall); n_fail++; end
    n_checks++; if (done !== 1'b0) begin $display("FAIL midrst_done got %b want 0", done); n_fail++; end
    n_checks++; if (result !== 32'h0) begin $display("FAIL midrst_result got %h want 0", result); n_fail++; end
    do_op(4'b0101, 32'd2, 32'd2, r, lat, bad, dc);
    n_checks++; if (r !== 32'd4) begin $display("FAIL post_rst_mul got %h want 00000004", r); n_fail++; end
    n_checks++; if (lat !== 34) begin $display("FAIL post_rst_latency got %0d want 34", lat); n_fail++; end
  endtask

  task automatic test_ignore;
    int lat;
    @(posedge clk); #1;
    start = 1'b1; aluop = 4'b0011; a = 32'd9; b = 32'd9;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin $display("FAIL nonmul_stall got %b want 0", stall); n_fail++; end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin $display("FAIL nonmul_busy got %b want 0", busy); n_fail++; end
    @(posedge clk); #1;
    start = 1'b1; aluop = 4'b0101; a = 32'd9; b = 32'd9;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      start = (k == 5);
      if (k == 5) begin a = 32'd1; b = 32'd1; end
      @(negedge clk);
      if (done === 1'b1) begin lat = k; break; end
    end
    n_checks++; if (lat !== 34) begin $display("FAIL restart_latency got %0d want 34", lat); n_fail++; end
    n_checks++; if (result !== 32'd81) begin $display("FAIL restart_ignored got %h want 00000051", result); n_fail++; end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2; int l1, l2, b1, b2, d1, d2;
    do_op(4'b0101, 32'd4, 32'd4, r1, l1, b1, d1);
    do_op(4'b0101, 32'd5, 32'd5, r2, l2, b2, d2);
    n_checks++; if (r1 !== 32'd16) begin $display("FAIL b2b_first got %h want 00000010", r1); n_fail++; end
    n_checks++; if (r2 !== 32'd25) begin $display("FAIL b2b_second got %h want 00000019", r2); n_fail++; end
    n_checks++; if (d2 - d1 !== 35) begin $display("FAIL b2b_spacing got %0d want 35", d2 - d1); n_fail++; end
    n_checks++; if (b1 !== 0) begin $display("FAIL b2b_stall1 got %0d bad cycles want 0", b1); n_fail++; end
    n_checks++; if (b2 !== 0) begin $display("FAIL b2b_stall2 got %0d bad cycles want 0", b2); n_fail++; end
  endtask

  initial begin
    test_reset;
    test_mul_basic;
    test_mulhu;
    test_mulh;
    test_reset_mid;
    test_ignore;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
